// File: rtl/dmem_sram_ctrl.sv
// Data-memory target for the LSU: byte-masked writes and word reads on an internal SRAM.
// One in-order response per request; a credit counter keeps response back-pressure lossless.
module dmem_sram_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int READ_LAT    = 1,
    parameter int RESP_DEPTH  = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    input  logic        req_we_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(RESP_DEPTH + 1);
    localparam int PW = $clog2(RESP_DEPTH);
    localparam logic [CW-1:0] DEPTH_C  = CW'(RESP_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(RESP_DEPTH - 1);

    if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_lat
        $fatal(1, "dmem_sram_ctrl: READ_LAT must be in 1..4");
    end
    if (RESP_DEPTH < READ_LAT + 1) begin : g_bad_depth
        $fatal(1, "dmem_sram_ctrl: RESP_DEPTH must be at least READ_LAT+1");
    end
    if (DEPTH_WORDS < 4 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0 || AW > 29) begin : g_bad_words
        $fatal(1, "dmem_sram_ctrl: DEPTH_WORDS must be a power of two in 4..2^29");
    end

    logic [AW-1:0]       idx;
    logic                addr_err;
    logic                accept;
    logic                pop;
    logic                push;
    logic                fifo_empty;
    logic [CW-1:0]       inflight;
    logic [CW-1:0]       fifo_cnt;
    logic                unused_addr_lsb;

    logic [CW-1:0]       out_cnt_q, out_cnt_d;
    logic [READ_LAT-1:0] pv_q, pv_d;
    logic [READ_LAT-1:0] pe_q, pe_d;
    logic [31:0]         pd_q [READ_LAT];
    logic [31:0]         pd_d [READ_LAT];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;

    logic [31:0]           mem_q [DEPTH_WORDS];
    logic [31:0]           fifo_data_q [RESP_DEPTH];
    logic [RESP_DEPTH-1:0] fifo_err_q;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Byte offset is the LSU's concern; only the word index and the out-of-range bits matter here.
    assign unused_addr_lsb = ^req_addr_i[1:0];
    assign idx             = req_addr_i[AW+1:2];
    assign addr_err        = |req_addr_i[31:AW+2];
    assign req_ready_o     = rst_i & (out_cnt_q < DEPTH_C);
    assign accept          = req_valid_i & req_ready_o;

    always_comb begin
        pv_d = '0;
        pe_d = '0;
        for (int k = 0; k < READ_LAT; k++) pd_d[k] = '0;
        pv_d[0] = accept;
        pe_d[0] = accept & addr_err;
        if (accept && !req_we_i && !addr_err) pd_d[0] = mem_q[idx];
        for (int k = 1; k < READ_LAT; k++) begin
            pv_d[k] = pv_q[k-1];
            pe_d[k] = pe_q[k-1];
            pd_d[k] = pd_q[k-1];
        end
    end

    // FIFO occupancy is whatever is outstanding but no longer travelling down the pipeline.
    always_comb begin
        inflight = '0;
        for (int k = 0; k < READ_LAT; k++) inflight = inflight + CW'(pv_q[k]);
        fifo_cnt   = out_cnt_q - inflight;
        fifo_empty = (fifo_cnt == '0);
        if (fifo_empty) begin
            rsp_valid_o = pv_q[READ_LAT-1];
            rsp_rdata_o = pd_q[READ_LAT-1];
            rsp_err_o   = pe_q[READ_LAT-1];
        end else begin
            rsp_valid_o = 1'b1;
            rsp_rdata_o = fifo_data_q[rd_ptr_q];
            rsp_err_o   = fifo_err_q[rd_ptr_q];
        end
        pop  = rsp_valid_o & rsp_ready_i;
        push = pv_q[READ_LAT-1] & ~(fifo_empty & pop);

        out_cnt_d = out_cnt_q;
        if (accept && !pop) begin
            out_cnt_d = out_cnt_q + CW'(1);
        end else if (!accept && pop) begin
            out_cnt_d = out_cnt_q - CW'(1);
        end
        wr_ptr_d = push ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = (pop && !fifo_empty) ? next_ptr(rd_ptr_q) : rd_ptr_q;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            out_cnt_q <= '0;
            pv_q      <= '0;
            pe_q      <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            for (int k = 0; k < READ_LAT; k++) pd_q[k] <= '0;
        end else begin
            out_cnt_q <= out_cnt_d;
            pv_q      <= pv_d;
            pe_q      <= pe_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            for (int k = 0; k < READ_LAT; k++) pd_q[k] <= pd_d[k];
        end
    end

    // Storage arrays carry no reset; the FIFO slots are only read while counted as occupied.
    always_ff @(posedge clk_i) begin
        if (accept && req_we_i && !addr_err) begin
            for (int i = 0; i < 4; i++) begin
                if (req_be_i[i]) mem_q[idx][8*i +: 8] <= req_wdata_i[8*i +: 8];
            end
        end
        if (push) begin
            fifo_data_q[wr_ptr_q] <= pd_q[READ_LAT-1];
            fifo_err_q[wr_ptr_q]  <= pe_q[READ_LAT-1];
        end
    end

endmodule

// File: doc/dmem_sram_ctrl.md
Name: dmem_sram_ctrl

Overview:
- Data-memory target that sits directly downstream of the core's DMEM port (LSU side of the MEM stage).
- Accepts one valid/ready request per cycle: address, write data, byte enables, write-enable. Performs byte-masked writes or full-word reads on an internal word-addressed SRAM array.
- Returns exactly one in-order response per request on a valid/ready response channel; stores also get a response, because the MEM/WB register waits on response valid.
- A credit counter plus response FIFO make back-pressure lossless with any read latency.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the array; power of two, ≥ 4.
- READ_LAT, 1: cycles from request accept edge to response valid; legal 1..4.
- RESP_DEPTH, 2: response FIFO entries and max outstanding requests; must be ≥ READ_LAT+1.

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous reset, active-low (asserted at 0)
- req_addr_i  in  32  byte address; word index = addr[log2(DEPTH_WORDS)+1:2]
- req_wdata_i  in  32  store data, already lane-aligned
- req_be_i  in  4  byte-lane enables for writes
- req_we_i  in  1  1 = write, 0 = read
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid & ready
- rsp_rdata_o  out  32  read word; 0 for writes and errors
- rsp_err_o  out  1  request was out of range
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid & ready

Behaviour:
- Reset (rst_i=0, async):
  - Clears the outstanding counter, pipeline valid bits and FIFO pointers.
  - Outputs held at: req_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
  - Array contents are not reset.
  - Reset mid-operation discards all in-flight responses. A write already accepted has completed; no partial write is possible.
- Accept: occurs when req_valid_i & req_ready_o at a rising edge.
  - req_ready_o = rst_i & (outstanding < RESP_DEPTH).
  - req_ready_o has no combinational path from rsp_ready_i or req_valid_i.
- Outstanding counter:
  - Increments on accept and decrements on response pop.
  - Both in the same cycle leaves it unchanged.
  - Never exceeds RESP_DEPTH and never underflows.
- Range check: error if any addr bit above the word-index field is 1.
  - On error: no array write; response has rdata=0, err=1.
  - addr[1:0] is ignored; the LSU owns alignment.
- Write:
  - On the accept edge, each lane i with be[i]=1 stores wdata[8i+7:8i]; other lanes are unchanged.
  - be=4'b0000 is a legal no-op write.
  - The response carries rdata=0, err=0.
- Read:
  - Array word is sampled at the accept edge into pipeline stage 1, then shifts through stages 2..READ_LAT.
  - A read accepted the cycle after a write to the same word returns the new data.
- Latency: response for a request accepted at edge t is visible on rsp_valid_o in cycle t+READ_LAT when the FIFO is empty.
  - The final pipeline stage bypasses into the outputs when the FIFO is empty.
  - The final stage is pushed into the FIFO only if not popped that cycle.
- Back-pressure:
  - The pipeline never stalls. The credit limit guarantees FIFO space for every in-flight response.
  - While rsp_valid_o=1 and rsp_ready_i=0, rsp_rdata_o and rsp_err_o hold stable.
- Throughput: with rsp_ready_i held 1, one request per cycle is sustained indefinitely (requires RESP_DEPTH ≥ READ_LAT+1).
- Ordering: responses are strictly in accept order.
- FIFO pointer wrap:
  - Pointers wrap modulo RESP_DEPTH.
  - Full and empty are distinguished by the outstanding count, not pointer equality.
- Illegal parameters (READ_LAT outside 1..4, RESP_DEPTH < READ_LAT+1) stop elaboration with a fatal error.

Test Plan:
- Reset then idle:
  - rst_i=0 for 3 cycles → req_ready_o=0, rsp_valid_o=0.
  - Release → req_ready_o=1 next cycle.
- Byte-masked write/readback:
  - Write 0x11223344 be=1111 to 0x10, then 0xAABBCCDD be=0101 to 0x10, then read 0x10.
  - → Read response 0x11BB33DD, err=0, READ_LAT cycles after accept.
  - → Both write responses have rdata=0.
- Streaming (READ_LAT=1, RESP_DEPTH=2, rsp_ready_i=1):
  - 8 back-to-back reads of preloaded words 0..7.
  - → Accepted on 8 consecutive cycles; responses on 8 consecutive cycles, in order.
- Back-pressure:
  - rsp_ready_i=0 while issuing reads.
  - → Exactly RESP_DEPTH accepted, then req_ready_o=0; head response held stable.
  - Raise rsp_ready_i → all responses drained in order; req_ready_o returns to 1.
- Out-of-range:
  - Write 0xFFFFFFFF to byte address DEPTH_WORDS*4 → err=1, rdata=0.
  - Subsequent read of word 0 → unchanged value, err=0.
- Reset mid-flight:
  - Assert rst_i with 2 outstanding reads → rsp_valid_o drops immediately.
  - After release, a fresh read returns correct data with no stale responses.
